// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
//   HALT_OPCODE : opcode[6:0] the processor decodes as HALT
//   ST_*        : loader FSM state encodings
//   is_halt()   : true when a 32-bit instruction word carries the HALT opcode
package imem_loader_pkg;

    localparam logic [6:0] HALT_OPCODE = 7'b1111111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_halt(input logic [31:0] word);
        return word[6:0] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   clear        : restart packing at lane 0 (discards any partial word)
//   accept       : a byte is being taken this cycle
//   in_byte      : byte to store in the current lane
//   word         : assembled word, valid when word_valid is high
//   word_valid   : high in the cycle the 4th byte of a word is accepted
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            lanes    <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (accept) begin
            case (byte_idx)
                2'd0:    lanes[7:0]   <= in_byte;
                2'd1:    lanes[15:8]  <= in_byte;
                2'd2:    lanes[23:16] <= in_byte;
                default: ;
            endcase
            // Index wraps 3 -> 0 so the next byte starts a new word.
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The top lane is taken straight from the bus so the word is complete in
    // the same cycle as the 4th handshake; the top registers it.
    assign word       = {in_byte, lanes};
    assign word_valid = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM loader: packs a host byte stream into 32-bit words, writes
// them from word 0 upward, pads the rest of the RAM with HALT and then
// releases the processor.
// Ports:
//   CLOCK_50, reset_n : clock and asynchronous active-low reset
//   start             : begin a load (IDLE/DONE only)
//   in_byte, in_valid : program byte stream
//   in_ready          : byte accepted when in_valid && in_ready
//   wr_en, wr_addr, wr_data : instruction RAM write port
//   cpu_hold          : processor held in reset
//   done              : RAM contents valid
//   overflow          : RAM filled without a HALT word
//   word_count        : program words written (pad words excluded)
//
// state | meaning
// IDLE  | after reset, waiting for start, processor held
// LOAD  | accepting bytes, writing program words
// FILL  | writing HALT_WORD to every address after the program
// DONE  | load complete, processor released, waiting for start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = 32'h0000007F
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;

    logic [1:0]  state;
    logic        halt_pending;
    logic        arm;
    logic        accept;
    logic [31:0] packed_word;
    logic        word_valid;

    assign arm    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept = in_valid && in_ready;

    imem_loader_byte_packer u_packer (
        .clk        (CLOCK_50),
        .rst_n      (reset_n),
        .clear      (arm),
        .accept     (accept),
        .in_byte    (in_byte),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            halt_pending <= 1'b0;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            overflow     <= 1'b0;
            word_count   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state        <= ST_LOAD;
                        halt_pending <= 1'b0;
                        in_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        overflow     <= 1'b0;
                        wr_addr      <= '0;
                        word_count   <= '0;
                    end
                end

                ST_LOAD: begin
                    // A write always lags its 4th byte by one cycle, and the
                    // next word needs four more bytes, so the write and the
                    // next word_valid never land in the same cycle.
                    if (wr_en) begin
                        word_count <= word_count + COUNT_ONE;
                        if (halt_pending) begin
                            if (wr_addr == LAST_ADDR) begin
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state   <= ST_FILL;
                                wr_addr <= wr_addr + ADDR_ONE;
                                wr_en   <= 1'b1;
                                wr_data <= HALT_WORD;
                            end
                        end else if (wr_addr == LAST_ADDR) begin
                            state    <= ST_DONE;
                            overflow <= 1'b1;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            wr_addr <= wr_addr + ADDR_ONE;
                        end
                    end
                    if (word_valid) begin
                        wr_en        <= 1'b1;
                        wr_data      <= packed_word;
                        halt_pending <= is_halt(packed_word);
                        // Stop taking bytes once the last word the RAM can
                        // hold, or the HALT word, has been assembled.
                        if (is_halt(packed_word) || (wr_addr == LAST_ADDR)) begin
                            in_ready <= 1'b0;
                        end
                    end
                end

                ST_FILL: begin
                    if (wr_addr == LAST_ADDR) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        wr_addr <= wr_addr + ADDR_ONE;
                        wr_en   <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
